// File: rtl/sobel_pkg.sv
// Shared defaults and window addressing for the Sobel hold stage.
package sobel_pkg;

  localparam int unsigned DefPixw = 24;
  localparam int unsigned DefRows = 3;
  localparam int unsigned DefCols = 3;

  // Bit offset of window element (r,c) in the flattened window bus; c=0 is the newest column.
  function automatic int unsigned win_idx(input int unsigned r, input int unsigned c,
                                          input int unsigned cols, input int unsigned pixw);
    return (r * cols + c) * pixw;
  endfunction

endpackage

// File: rtl/sobel_line_tracker.sv
// Line position tracker: column counter, window fill level, end/start-of-line handling and the
// sticky line-framing error. State only advances on an accepted pixel.
module sobel_line_tracker
  import sobel_pkg::*;
#(
  parameter int unsigned COLS  = DefCols,
  parameter int unsigned LINEW = 1024,
  parameter int unsigned CW    = $clog2(LINEW)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          accept_i,
  input  logic          sol_i,
  input  logic          clr_err_i,
  output logic [CW-1:0] col_o,
  output logic          eol_o,
  output logic          full_o,
  output logic          line_err_o
);

  localparam int unsigned FW = $clog2(COLS + 1);
  localparam logic [CW-1:0] LastCol = CW'(LINEW - 1);
  localparam logic [FW-1:0] FullCnt = FW'(COLS);

  logic [CW-1:0] col_q, col_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [FW-1:0] fill_upd;
  logic          err_q, err_d;
  logic          err_set;

  // Column and fill bookkeeping for the pixel currently offered.
  always_comb begin
    col_o    = col_q;
    fill_upd = fill_q;
    err_set  = 1'b0;
    if (sol_i) begin
      col_o    = '0;
      fill_upd = FW'(1);
      // A start of line anywhere but col 0 means the previous line was short.
      err_set  = (col_q != '0);
    end else begin
      fill_upd = (fill_q < FullCnt) ? fill_q + FW'(1) : FullCnt;
    end
    eol_o  = (col_o == LastCol);
    full_o = (fill_upd >= FullCnt);
    col_d  = eol_o ? '0 : col_o + CW'(1);
    // Empty the window at end of line so no window straddles two lines.
    fill_d = eol_o ? '0 : fill_upd;
  end

  // Sticky error: a new error wins over a coincident clear.
  always_comb begin
    err_d = err_q;
    if (accept_i && err_set) begin
      err_d = 1'b1;
    end else if (clr_err_i) begin
      err_d = 1'b0;
    end
  end

  // Tracker state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q  <= '0;
      fill_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (accept_i) begin
        col_q  <= col_d;
        fill_q <= fill_d;
      end
      err_q <= err_d;
    end
  end

  assign line_err_o = err_q;

endmodule

// File: rtl/sobel_window_hold.sv
// Sliding ROWS x COLS pixel window between the row buffers and the Sobel kernel, with
// valid/ready on both sides and line position tracking.
module sobel_window_hold
  import sobel_pkg::*;
#(
  parameter int unsigned ROWS  = DefRows,
  parameter int unsigned COLS  = DefCols,
  parameter int unsigned PIXW  = DefPixw,
  parameter int unsigned LINEW = 1024,
  parameter int unsigned CW    = $clog2(LINEW)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ROWS*PIXW-1:0]      in_pix,
  input  logic                      in_sol,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ROWS*COLS*PIXW-1:0] out_win,
  output logic [CW-1:0]             out_col,
  output logic                      out_eol,
  input  logic                      clr_err,
  output logic                      line_err
);

  logic          accept;
  logic [CW-1:0] trk_col;
  logic          trk_eol;
  logic          trk_full;

  logic          out_valid_q, out_valid_d;
  logic [CW-1:0] out_col_q, out_col_d;
  logic          out_eol_q, out_eol_d;

  logic [PIXW-1:0] win_q [ROWS][COLS];

  // A held window blocks new input unless it is consumed in the same cycle.
  assign in_ready = en & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;

  sobel_line_tracker #(
    .COLS  (COLS),
    .LINEW (LINEW),
    .CW    (CW)
  ) u_tracker (
    .clk        (clk),
    .reset      (reset),
    .accept_i   (accept),
    .sol_i      (in_sol),
    .clr_err_i  (clr_err),
    .col_o      (trk_col),
    .eol_o      (trk_eol),
    .full_o     (trk_full),
    .line_err_o (line_err)
  );

  // Window shift array: column 0 takes the new taps, older columns move one step deeper.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      if (c == 0) begin : g_newest
        // Newest column loads the incoming tap for this row.
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            win_q[r][c] <= '0;
          end else if (accept) begin
            win_q[r][c] <= in_pix[r*PIXW +: PIXW];
          end
        end
      end else begin : g_older
        // Older columns take the value of their younger neighbour.
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            win_q[r][c] <= '0;
          end else if (accept) begin
            win_q[r][c] <= win_q[r][c-1];
          end
        end
      end
      assign out_win[win_idx(r, c, COLS, PIXW) +: PIXW] = win_q[r][c];
    end
  end

  // Output handshake next state: reload on accept, drop valid once consumed.
  always_comb begin
    out_valid_d = out_valid_q;
    out_col_d   = out_col_q;
    out_eol_d   = out_eol_q;
    if (accept) begin
      out_valid_d = trk_full;
      out_col_d   = trk_col;
      out_eol_d   = trk_eol;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output handshake registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_col_q   <= '0;
      out_eol_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_col_q   <= out_col_d;
      out_eol_q   <= out_eol_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_col   = out_col_q;
  assign out_eol   = out_eol_q;

endmodule
